// File: rtl/dac_spi_driver.sv
// dac_spi_driver
// Samples an 8-bit DAC code at a fixed audio rate and ships it to an
// MCP4901-class DAC as a 16-bit SPI mode-0 frame, then strobes LDAC.
//
// Ports:
//   clk, rst_n      system clock, async active-low reset
//   sample[7:0]     parallel DAC code from the sound generator
//   enable          start a frame on each sample tick while high
//   mute            clears the SHDN_n frame bit (DAC output high-Z)
//   spi_cs_n        chip select, active low
//   spi_sck         SPI clock, idles low
//   spi_mosi        serial data, MSB first
//   spi_ldac_n      DAC latch strobe, active low
//   busy            high from frame start until the LDAC phase ends
//   frame_done      1-cycle pulse in the last LDAC cycle
//   overrun         1-cycle pulse when a tick arrives while a frame is in flight
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a sample tick with enable high
// SETUP | cs_n low, sck low for CLK_DIV cycles before the first bit
// SHIFT | 16 bits, sck high then low for CLK_DIV cycles each
// HOLD  | cs_n still low for CLK_DIV cycles after the last bit
// LOAD  | cs_n high, ldac_n low for CLK_DIV cycles
module dac_spi_driver #(
  parameter int         CLK_DIV    = 4,
  parameter int         SAMPLE_DIV = 2500,
  parameter logic [3:0] CFG_BITS   = 4'b0111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample,
  input  logic       enable,
  input  logic       mute,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic       spi_mosi,
  output logic       spi_ldac_n,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [PW-1:0] PH_LOAD   = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_LOAD
  } state_t;

  state_t          state;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [PW-1:0]   phase_cnt;
  logic [3:0]      bit_cnt;
  logic [15:0]     frame_sr;
  logic [15:0]     frame_next;

  assign tick       = (tick_cnt == TICK_LAST);
  assign frame_next = {CFG_BITS[3:1], CFG_BITS[0] & ~mute, sample, 4'b0000};

  // Free-running sample timer, independent of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // phase_cnt is a down-counter loaded with CLK_DIV-1; a phase ends when it reaches 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      phase_cnt  <= '0;
      bit_cnt    <= '0;
      frame_sr   <= '0;
      spi_cs_n   <= 1'b1;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_ldac_n <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= tick && (state != ST_IDLE);
      unique case (state)
        ST_IDLE: begin
          if (tick && enable) begin
            frame_sr  <= frame_next;
            spi_mosi  <= frame_next[15];
            spi_cs_n  <= 1'b0;
            busy      <= 1'b1;
            phase_cnt <= PH_LOAD;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (phase_cnt == '0) begin
            spi_sck   <= 1'b1;
            bit_cnt   <= '0;
            phase_cnt <= PH_LOAD;
            state     <= ST_SHIFT;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        ST_SHIFT: begin
          if (phase_cnt != '0) begin
            phase_cnt <= phase_cnt - 1'b1;
          end else if (spi_sck) begin
            // Falling edge: present the next bit. Zero fill makes mosi 0
            // after the last bit, which is already 0 in this frame format.
            spi_sck   <= 1'b0;
            spi_mosi  <= frame_sr[14];
            frame_sr  <= {frame_sr[14:0], 1'b0};
            phase_cnt <= PH_LOAD;
          end else if (bit_cnt == 4'd15) begin
            spi_mosi  <= 1'b0;
            phase_cnt <= PH_LOAD;
            state     <= ST_HOLD;
          end else begin
            spi_sck   <= 1'b1;
            bit_cnt   <= bit_cnt + 1'b1;
            phase_cnt <= PH_LOAD;
          end
        end
        ST_HOLD: begin
          if (phase_cnt == '0) begin
            spi_cs_n   <= 1'b1;
            spi_ldac_n <= 1'b0;
            // With a single-cycle LOAD phase, that cycle is also the last one.
            frame_done <= (CLK_DIV == 1);
            phase_cnt  <= PH_LOAD;
            state      <= ST_LOAD;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        ST_LOAD: begin
          if (phase_cnt == '0) begin
            spi_ldac_n <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            // Registered pulse lands in the final LOAD cycle.
            frame_done <= (phase_cnt == PW'(1));
            phase_cnt  <= phase_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_driver.sv
// Bench for dac_spi_driver: three instances (CLK_DIV/SAMPLE_DIV = 2/200,
// 2/60 and 1/40) driven by one directed sequence, with per-instance bus
// monitors that decode frames off the SPI pins.
module tb_dac_spi_driver;

  logic       clk;
  logic       rst_n;
  logic [7:0] smp     [3];
  logic       en      [3];
  logic       mute    [3];
  logic       cs_n_w  [3];
  logic       sck_w   [3];
  logic       mosi_w  [3];
  logic       ldac_w  [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic       ovr_w   [3];

  int         pass_cnt;
  int         total_cnt;
  int         fail_cnt;
  int         edge_cnt;
  logic [15:0] exp1;
  logic [7:0] exp2 [256];
  logic [7:0] wr;

  dac_spi_driver #(.CLK_DIV(2), .SAMPLE_DIV(200)) u0 (
    .clk(clk), .rst_n(rst_n), .sample(smp[0]), .enable(en[0]), .mute(mute[0]),
    .spi_cs_n(cs_n_w[0]), .spi_sck(sck_w[0]), .spi_mosi(mosi_w[0]),
    .spi_ldac_n(ldac_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]),
    .overrun(ovr_w[0]));

  dac_spi_driver #(.CLK_DIV(2), .SAMPLE_DIV(60)) u1 (
    .clk(clk), .rst_n(rst_n), .sample(smp[1]), .enable(en[1]), .mute(mute[1]),
    .spi_cs_n(cs_n_w[1]), .spi_sck(sck_w[1]), .spi_mosi(mosi_w[1]),
    .spi_ldac_n(ldac_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]),
    .overrun(ovr_w[1]));

  dac_spi_driver #(.CLK_DIV(1), .SAMPLE_DIV(40)) u2 (
    .clk(clk), .rst_n(rst_n), .sample(smp[2]), .enable(en[2]), .mute(mute[2]),
    .spi_cs_n(cs_n_w[2]), .spi_sck(sck_w[2]), .spi_mosi(mosi_w[2]),
    .spi_ldac_n(ldac_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]),
    .overrun(ovr_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge count since reset release; tick of an instance falls on edges that
  // are multiples of its SAMPLE_DIV. Also records the u2 sample at each tick.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= 0;
      wr       <= '0;
    end else begin
      edge_cnt <= edge_cnt + 1;
      if (en[2] && ((edge_cnt + 1) % 40 == 0)) begin
        exp2[wr] <= smp[2];
        wr       <= wr + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_mon
    localparam int D = (g == 2) ? 1 : 2;
    logic [15:0] shreg, lf_frame;
    int          bits, cs_cnt, ldac_cnt, busy_cnt;
    int          lf_bits, lf_cs, lf_ldac, lf_busy, lf_fall, rise_edge;
    int          nframes, ndone, novr, viol, active, bad, dbad;
    logic        p_sck, p_cs, p_mosi, p_busy;
    logic [7:0]  rd;

    always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shreg <= '0; lf_frame <= '0;
        bits <= 0; cs_cnt <= 0; ldac_cnt <= 0; busy_cnt <= 0;
        lf_bits <= 0; lf_cs <= 0; lf_ldac <= 0; lf_busy <= 0; lf_fall <= 0;
        rise_edge <= 0; nframes <= 0; ndone <= 0; novr <= 0; viol <= 0;
        active <= 0; bad <= 0; dbad <= 0; rd <= '0;
        p_sck <= 1'b0; p_cs <= 1'b1; p_mosi <= 1'b0; p_busy <= 1'b0;
      end else begin
        p_sck  <= sck_w[g];
        p_cs   <= cs_n_w[g];
        p_mosi <= mosi_w[g];
        p_busy <= busy_w[g];
        if (!p_sck && sck_w[g]) begin
          shreg <= {shreg[14:0], mosi_w[g]};
          bits  <= bits + 1;
        end
        if (!cs_n_w[g]) cs_cnt <= cs_cnt + 1;
        if (!ldac_w[g]) ldac_cnt <= ldac_cnt + 1;
        if (busy_w[g]) busy_cnt <= busy_cnt + 1;
        if (!p_busy && busy_w[g]) rise_edge <= edge_cnt;
        if (done_w[g]) ndone <= ndone + 1;
        if (ovr_w[g]) novr <= novr + 1;
        if ((!cs_n_w[g] && !ldac_w[g]) || (cs_n_w[g] && sck_w[g]))
          viol <= viol + 1;
        else if (!cs_n_w[g] && !p_cs && (mosi_w[g] != p_mosi) && !(p_sck && !sck_w[g]))
          viol <= viol + 1;
        if (!cs_n_w[g] || sck_w[g] || !ldac_w[g] || busy_w[g]) active <= active + 1;
        if (p_busy && !busy_w[g]) begin
          lf_frame <= shreg;
          lf_bits  <= bits;
          lf_cs    <= cs_cnt;
          lf_ldac  <= ldac_cnt;
          lf_busy  <= busy_cnt;
          lf_fall  <= edge_cnt;
          nframes  <= nframes + 1;
          if (bits != 16 || cs_cnt != 34 * D || ldac_cnt != D || busy_cnt != 35 * D)
            bad <= bad + 1;
          if (g == 1 && shreg != exp1) dbad <= dbad + 1;
          if (g == 2) begin
            if (rd == wr || shreg != {4'h7, exp2[rd], 4'h0}) dbad <= dbad + 1;
            rd <= rd + 1'b1;
          end
          shreg <= '0; bits <= 0; cs_cnt <= 0; ldac_cnt <= 0; busy_cnt <= 0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_u0_frames(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (g_mon[0].nframes >= target) break;
    end
  endtask

  // {cs_n, sck, mosi, ldac_n, busy, frame_done, overrun}
  function automatic logic [6:0] pins(input int g);
    return {cs_n_w[g], sck_w[g], mosi_w[g], ldac_w[g], busy_w[g], done_w[g], ovr_w[g]};
  endfunction

  initial begin
    int e0, t0;
    pass_cnt = 0; total_cnt = 0; fail_cnt = 0;
    exp1 = 16'h0000;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp[i] = 8'h00; en[i] = 1'b0; mute[i] = 1'b0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_pins_u0", 32'(pins(0)), 32'b1001000);
    check("rst_pins_u2", 32'(pins(2)), 32'b1001000);
    rst_n = 1'b1;

    // Idle with enable low: ticks ignored
    repeat (1000) @(negedge clk);
    @(posedge clk); #1;
    check("idle_activity", 32'(g_mon[0].active), 0);
    check("idle_frame_done", 32'(g_mon[0].ndone), 0);

    // Plain frame, sample A5
    @(negedge clk);
    e0 = edge_cnt;
    t0 = (e0 / 200 + 1) * 200;
    smp[0] = 8'hA5; en[0] = 1'b1;
    wait_u0_frames(1, 400);
    en[0] = 1'b0;
    check("a5_frame_seen", 32'(g_mon[0].nframes), 1);
    check("a5_frame", 32'(g_mon[0].lf_frame), 32'h7A50);
    check("a5_sck_edges", 32'(g_mon[0].lf_bits), 16);
    check("a5_cs_low", 32'(g_mon[0].lf_cs), 68);
    check("a5_ldac_low", 32'(g_mon[0].lf_ldac), 2);
    check("a5_busy_high", 32'(g_mon[0].lf_busy), 70);
    check("a5_start_edge", 32'(g_mon[0].rise_edge), 32'(t0));
    check("a5_frame_len", 32'(g_mon[0].lf_fall - (t0 - 1)), 71);
    check("a5_frame_done", 32'(g_mon[0].ndone), 1);

    // Muted FF; sample and enable changed mid-frame
    @(negedge clk);
    mute[0] = 1'b1; smp[0] = 8'hFF; en[0] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (busy_w[0]) break;
    end
    check("mute_busy_seen", 32'(busy_w[0]), 1);
    repeat (20) @(negedge clk);
    smp[0] = 8'h00; en[0] = 1'b0;
    wait_u0_frames(2, 200);
    check("mute_frame", 32'(g_mon[0].lf_frame), 32'h6FF0);
    check("mute_sck_edges", 32'(g_mon[0].lf_bits), 16);
    check("mute_frame_done", 32'(g_mon[0].ndone), 2);
    repeat (450) @(negedge clk);
    check("disabled_no_frame", 32'(g_mon[0].nframes), 2);
    check("u0_shape_bad", 32'(g_mon[0].bad), 0);
    check("u0_bus_viol", 32'(g_mon[0].viol), 0);
    mute[0] = 1'b0;

    // Reset pulse at the 8th sck rising edge
    @(negedge clk);
    smp[0] = 8'h5A; en[0] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (g_mon[0].bits >= 8) break;
    end
    check("rp_reached_bit8", 32'(g_mon[0].bits), 8);
    rst_n = 1'b0;
    #1;
    check("rp_async_idle", 32'(pins(0)), 32'b1001000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_u0_frames(1, 400);
    en[0] = 1'b0;
    check("rp_frame", 32'(g_mon[0].lf_frame), 32'h75A0);
    check("rp_sck_edges", 32'(g_mon[0].lf_bits), 16);
    check("rp_start_edge", 32'(g_mon[0].rise_edge), 200);
    check("rp_bus_viol", 32'(g_mon[0].viol), 0);

    // Overrun on u1, sawtooth on u2
    @(negedge clk);
    exp1 = 16'h73C0; smp[1] = 8'h3C; en[1] = 1'b1;
    smp[2] = 8'h00; en[2] = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      smp[2] = smp[2] + 8'd1;
    end
    en[1] = 1'b0; en[2] = 1'b0;
    repeat (150) @(negedge clk);
    @(posedge clk); #1;
    check("ovr_frames", 32'(g_mon[1].nframes), 5);
    check("ovr_pulses", 32'(g_mon[1].novr), 5);
    check("ovr_shape_bad", 32'(g_mon[1].bad), 0);
    check("ovr_data_bad", 32'(g_mon[1].dbad), 0);
    check("ovr_bus_viol", 32'(g_mon[1].viol), 0);
    check("saw_frames", 32'(g_mon[2].nframes), 15);
    check("saw_overrun", 32'(g_mon[2].novr), 0);
    check("saw_shape_bad", 32'(g_mon[2].bad), 0);
    check("saw_data_bad", 32'(g_mon[2].dbad), 0);
    check("saw_all_consumed", 32'(g_mon[2].rd), 32'(wr));
    check("saw_bus_viol", 32'(g_mon[2].viol), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
